bcd_digit_scanner: RTL and testbench

- Time-multiplexed scan driver that sits directly upstream of the BCD-to-seven-segment decoder.
- Holds an N-digit packed BCD word and presents one digit at a time on the decoder's D/C/B/A and BI inputs.
- Drives a one-hot digit-enable bus for the common-anode/cathode digit drivers.
- Uses double-buffered loading, so digit updates appear only at frame boundaries and never tear mid-frame.

---
 rtl/bcd_digit_scanner.sv | 148 ++++++++++++++
 tb/tb_bcd_digit_scanner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_scanner.sv
// bcd_digit_scanner: time-multiplexed scan driver for a BCD-to-seven-segment
// decoder. It holds an N-digit packed BCD word and presents one digit per slot
// on bcd_out/bi_out, together with a one-hot digit enable. New words are
// double-buffered and take effect only at frame boundaries, so a frame never
// tears.
// Each slot is one dead (all-blank) cycle followed by PRESCALE-1 active cycles.
// Optional feature: define BCD_SCAN_LZB_EN to blank leading zeros (digit 0 is
// never blanked).
module bcd_digit_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              bcd_out,
  output logic                    bi_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_pulse,
  output logic                    err
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [W-1:0]  display_reg;
  logic [W-1:0]  pending_reg;
  logic          pending_valid;

  logic          tick;
  logic          frame_edge;
  logic [3:0]    cur_nib;
  logic          lz_blank;
  logic [NUM_DIGITS-1:0] sel_onehot;
  logic [W-1:0]  display_next;
  logic          display_wr;

  assign tick       = en && (cnt == CNT_MAX);
  assign frame_edge = tick && (idx == IDX_MAX);

  // True when any nibble of the word is outside 0..9.
  function automatic logic has_invalid(input logic [W-1:0] word);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (word[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Select the current digit, its one-hot enable and the leading-zero blank.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    cur_nib    = '0;
    sel_onehot = '0;
    lz_blank   = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib       = display_reg[4*k +: 4];
        sel_onehot[k] = 1'b1;
      end
    end
`ifdef BCD_SCAN_LZB_EN
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if ((idx == IW'(k)) && ((display_reg >> (4*k)) == '0)) lz_blank = 1'b1;
    end
`endif
  end

  // Decide what the displayed word becomes at a frame boundary; a load on the
  // boundary edge itself bypasses the pending buffer so the newest word wins.
  always_comb begin
    display_next = display_reg;
    display_wr   = 1'b0;
    if (frame_edge) begin
      if (load) begin
        display_next = digits_in;
        display_wr   = 1'b1;
      end else if (pending_valid) begin
        display_next = pending_reg;
        display_wr   = 1'b1;
      end
    end
  end

  // Prescaler and digit index; both freeze while en is low.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Double buffer: pending word capture and frame-boundary transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg   <= '0;
      pending_valid <= 1'b0;
      display_reg   <= '0;
      err           <= 1'b0;
    end else begin
      if (load) pending_reg <= digits_in;
      if (frame_edge)  pending_valid <= 1'b0;
      else if (load)   pending_valid <= 1'b1;
      if (display_wr) begin
        display_reg <= display_next;
        err         <= has_invalid(display_next);
      end
    end
  end

  // Output register: dead cycle on tick or when disabled, else current digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel   <= '0;
      bcd_out     <= '0;
      bi_out      <= 1'b0;
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= frame_edge;
      if (tick || !en) begin
        digit_sel <= '0;
        bcd_out   <= '0;
        bi_out    <= 1'b0;
      end else begin
        digit_sel <= sel_onehot;
        bcd_out   <= cur_nib;
        bi_out    <= (cur_nib <= 4'd9) && !lz_blank;
      end
    end
  end

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Self-checking bench for bcd_digit_scanner (NUM_DIGITS=4, PRESCALE=4).
// The reference model tracks the number of enabled clock edges since reset and
// derives slot, digit and dead cycles from that count with plain arithmetic.
module tb_bcd_digit_scanner;

  localparam int N = 4;
  localparam int P = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] digits_in = '0;
  logic [3:0]   bcd_out;
  logic         bi_out;
  logic [N-1:0] digit_sel;
  logic         frame_pulse;
  logic         err;

  bcd_digit_scanner #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
    .bcd_out(bcd_out), .bi_out(bi_out), .digit_sel(digit_sel),
    .frame_pulse(frame_pulse), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model state.
  int           m_ecount;
  logic [W-1:0] m_disp;
  logic [W-1:0] m_pend;
  bit           m_pv;
  logic [3:0]   x_bcd;
  logic         x_bi;
  logic [N-1:0] x_sel;
  logic         x_fp;
  logic         x_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".bcd_out"},     32'(bcd_out),     32'(x_bcd));
    check({ctx, ".bi_out"},      32'(bi_out),      32'(x_bi));
    check({ctx, ".digit_sel"},   32'(digit_sel),   32'(x_sel));
    check({ctx, ".frame_pulse"}, 32'(frame_pulse), 32'(x_fp));
    check({ctx, ".err"},         32'(err),         32'(x_err));
  endtask

  function automatic bit word_has_invalid(input logic [W-1:0] w);
    for (int k = 0; k < N; k++) if (((w >> (4*k)) & 'hF) > 9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_ecount = 0; m_disp = '0; m_pend = '0; m_pv = 0;
    x_bcd = '0; x_bi = 0; x_sel = '0; x_fp = 0; x_err = 0;
  endtask

  // One clock edge of the reference behaviour, from the inputs seen at that edge.
  task automatic model_step(input bit e, input bit l, input logic [W-1:0] d);
    int pos, digit;
    bit tk, frame;
    logic [3:0] nib;
    pos   = m_ecount % P;
    digit = (m_ecount / P) % N;
    tk    = e && (pos == P - 1);
    frame = tk && (digit == N - 1);
    if (!e || tk) begin
      x_sel = '0; x_bcd = '0; x_bi = 0;
    end else begin
      nib   = 4'((m_disp >> (4*digit)) & 'hF);
      x_sel = N'(1) << digit;
      x_bcd = nib;
      x_bi  = (nib <= 9);
`ifdef BCD_SCAN_LZB_EN
      if (digit > 0 && (m_disp >> (4*digit)) == 0) x_bi = 0;
`endif
    end
    x_fp = frame;
    if (frame) begin
      if (l) begin m_disp = d; m_pv = 0; end
      else if (m_pv) begin m_disp = m_pend; m_pv = 0; end
    end else if (l) begin
      m_pend = d; m_pv = 1;
    end
    x_err = word_has_invalid(m_disp);
    if (e) m_ecount = (m_ecount + 1) % (N * P);
  endtask

  function automatic bit next_is_boundary();
    return ((m_ecount % P) == P - 1) && (((m_ecount / P) % N) == N - 1);
  endfunction

  // Drive inputs (just after an edge), advance one edge, then compare.
  task automatic do_cycle(input string ctx, input bit e, input bit l, input logic [W-1:0] d);
    en = e; load = l; digits_in = d;
    model_step(e, l, d);
    @(posedge clk); #1;
    cyc++;
    check_outputs(ctx);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; digits_in = '0;
    #1;
    model_reset();
    check_outputs("reset");
    @(posedge clk); #1;
    check_outputs("reset_hold");
    rst_n = 1'b1;
  endtask

  task automatic run_to_boundary(input string ctx);
    for (int i = 0; i < N * P && !next_is_boundary(); i++) do_cycle(ctx, 1, 0, '0);
  endtask

  int fp_edge;
  logic [W-1:0] rnd;

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Idle with en low: everything stays blank, no frame pulses.
    for (int i = 0; i < 24; i++) do_cycle("idle", 0, 0, '0);

    // Basic scan from reset; first frame boundary is the 16th edge.
    do_reset();
    fp_edge = 0;
    for (int i = 1; i <= 16; i++) begin
      do_cycle("basic", 1, (i == 2), 16'h1234);
      if (frame_pulse && fp_edge == 0) fp_edge = i;
    end
    check("first_frame_edge", 32'(fp_edge), 32'd16);
    for (int i = 0; i < 16; i++) do_cycle("show1234", 1, 0, '0);

    // Double buffer: two loads in one frame, last one wins at the boundary.
    for (int i = 0; i < 16; i++) begin
      if (i == 3)       do_cycle("dbuf", 1, 1, 16'h5678);
      else if (i == 9)  do_cycle("dbuf", 1, 1, 16'h9999);
      else              do_cycle("dbuf", 1, 0, '0);
    end
    for (int i = 0; i < 16; i++) do_cycle("show9999", 1, 0, '0);

    // Coincident load on the boundary edge, then a boundary with nothing pending.
    run_to_boundary("to_bnd");
    check("boundary_found", 32'(next_is_boundary()), 32'd1);
    do_cycle("coincident", 1, 1, 16'h0042);
    for (int i = 0; i < 32; i++) do_cycle("show0042", 1, 0, '0);

    // Invalid BCD nibble sets err and blanks that slot; a valid word clears err.
    do_cycle("ld_12A4", 1, 1, 16'h12A4);
    run_to_boundary("to_bnd_a");
    for (int i = 0; i < 16; i++) do_cycle("show12A4", 1, 0, '0);
    check("err_set", 32'(err), 32'd1);
    do_cycle("ld_0005", 1, 1, 16'h0005);
    run_to_boundary("to_bnd_5");
    for (int i = 0; i < 17; i++) do_cycle("show0005", 1, 0, '0);
    check("err_clear", 32'(err), 32'd0);

    // Drop en mid-slot, hold for a while, then resume the same slot.
    for (int i = 0; i < 6; i++) do_cycle("pre_pause", 1, 0, '0);
    for (int i = 0; i < 7; i++) do_cycle("paused", 0, (i == 2), 16'h0307);
    for (int i = 0; i < 24; i++) do_cycle("resumed", 1, 0, '0);

    // Randomized traffic: en mostly high, occasional loads of mixed words.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 2))
        0: rnd = W'($urandom);
        1: for (int k = 0; k < N; k++) rnd[4*k +: 4] = 4'($urandom_range(0, 9));
        default: rnd = W'($urandom_range(0, 99));
      endcase
      do_cycle("random", $urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, rnd);
    end

    // Reset mid-frame with a pending word; it must be lost.
    do_cycle("pre_rst_ld", 1, 1, 16'h8765);
    do_cycle("pre_rst", 1, 0, '0);
    do_reset();
    for (int i = 0; i < 40; i++) do_cycle("post_rst", 1, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
